pci_cfg_target: RTL and testbench



---
 rtl/pci_cfg_target.sv | 142 ++++++++++++++
 tb/tb_pci_cfg_target.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pci_cfg_target.sv
// Simplified PCI configuration-space target: claims config read/write cycles,
// inserts programmable wait states and completes a single data phase.
//
// state | meaning
// IDLE  | waiting for an address phase (pci_frame low)
// WAIT  | claimed, devsel asserted, counting down wait states
// DATA  | trdy asserted, waiting for pci_irdy to complete the transfer
// TAR   | outputs released for one turnaround cycle
// DRAIN | waiting for pci_frame high before accepting a new address phase
module pci_cfg_target #(
  parameter logic [15:0] VENDOR_ID   = 16'h1234,
  parameter logic [15:0] DEVICE_ID   = 16'h5678,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        pci_clk,
  input  logic        pci_rst_n,
  input  logic        pci_frame,
  input  logic        pci_irdy,
  input  logic [31:0] pci_addr,
  input  logic [3:0]  pci_cbe,
  input  logic [31:0] pci_wdata,
  output logic [31:0] pci_data,
  output logic        pci_trdy,
  output logic        pci_devsel
);

  localparam logic [3:0] CMD_READ  = 4'h1;
  localparam logic [3:0] CMD_WRITE = 4'h2;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_TAR,
    S_DRAIN
  } state_t;

  state_t      state;
  logic [5:0]  addr_q;
  logic        is_write;
  logic [2:0]  wcnt;
  logic [31:0] counter;
  // Entries 0 and 15 are never written; those dwords come from the ID and counter.
  logic [31:0] regs [16];

  logic [5:0]  rd_idx;
  logic        rd_is_write;
  logic [31:0] rd_val;
  logic        claim;
  logic        wr_ok;
  logic        unused_addr;

  assign unused_addr = ^{pci_addr[31:8], pci_addr[1:0]};
  assign claim = (pci_cbe == CMD_READ) || (pci_cbe == CMD_WRITE);
  assign wr_ok = is_write && (addr_q[5:4] == 2'b00) &&
                 (addr_q[3:0] != 4'd0) && (addr_q[3:0] != 4'd15);

  // With zero wait states the read value is needed before addr_q is loaded.
  always_comb begin
    rd_idx      = (state == S_IDLE) ? pci_addr[7:2] : addr_q;
    rd_is_write = (state == S_IDLE) ? (pci_cbe == CMD_WRITE) : is_write;
    rd_val      = '0;
    if (!rd_is_write && (rd_idx[5:4] == 2'b00)) begin
      case (rd_idx[3:0])
        4'd0:    rd_val = {DEVICE_ID, VENDOR_ID};
        4'd15:   rd_val = counter;
        default: rd_val = regs[rd_idx[3:0]];
      endcase
    end
  end

  always_ff @(posedge pci_clk or negedge pci_rst_n) begin
    if (!pci_rst_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      is_write   <= 1'b0;
      wcnt       <= '0;
      counter    <= '0;
      pci_trdy   <= 1'b1;
      pci_devsel <= 1'b1;
      pci_data   <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!pci_frame) begin
            addr_q   <= pci_addr[7:2];
            is_write <= (pci_cbe == CMD_WRITE);
            if (claim) begin
              pci_devsel <= 1'b0;
              if (WAIT_INIT == 3'd0) begin
                pci_trdy <= 1'b0;
                pci_data <= rd_val;
                state    <= S_DATA;
              end else begin
                wcnt  <= WAIT_INIT;
                state <= S_WAIT;
              end
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_WAIT: begin
          if (wcnt <= 3'd1) begin
            wcnt     <= '0;
            pci_trdy <= 1'b0;
            pci_data <= rd_val;
            state    <= S_DATA;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        S_DATA: begin
          if (!pci_irdy) begin
            if (wr_ok) begin
              for (int b = 0; b < 4; b++) begin
                if (!pci_cbe[b]) regs[addr_q[3:0]][8*b +: 8] <= pci_wdata[8*b +: 8];
              end
            end
            counter    <= counter + 32'd1;
            pci_trdy   <= 1'b1;
            pci_devsel <= 1'b1;
            pci_data   <= '0;
            state      <= S_TAR;
          end
        end
        S_TAR: begin
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pci_frame) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_cfg_target.sv
// Directed bench for pci_cfg_target: transaction-level register model plus
// per-cycle output expectations derived from the bus timing rules.
module tb_pci_cfg_target;

  localparam int W = 1;
  localparam logic [15:0] VID = 16'h1234;
  localparam logic [15:0] DID = 16'h5678;

  logic        clk;
  logic        pci_rst_n;
  logic        pci_frame;
  logic        pci_irdy;
  logic [31:0] pci_addr;
  logic [3:0]  pci_cbe;
  logic [31:0] pci_wdata;
  logic [31:0] pci_data;
  logic        pci_trdy;
  logic        pci_devsel;

  pci_cfg_target #(.VENDOR_ID(VID), .DEVICE_ID(DID), .WAIT_CYCLES(W)) dut (
    .pci_clk   (clk),
    .pci_rst_n (pci_rst_n),
    .pci_frame (pci_frame),
    .pci_irdy  (pci_irdy),
    .pci_addr  (pci_addr),
    .pci_cbe   (pci_cbe),
    .pci_wdata (pci_wdata),
    .pci_data  (pci_data),
    .pci_trdy  (pci_trdy),
    .pci_devsel(pci_devsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int dev_tot = 0;
  int trdy_tot = 0;

  logic        exp_trdy = 1'b1;
  logic        exp_devsel = 1'b1;
  logic [31:0] exp_data = '0;

  logic [31:0] mregs [16];
  logic [31:0] mcount;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mcount = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] cmd, input logic [31:0] addr);
    int idx;
    idx = int'(addr[5:2]);
    if (cmd != 4'h1 || addr[7:6] != 2'b00) return 32'h0;
    if (idx == 0) return {DID, VID};
    if (idx == 15) return mcount;
    return mregs[idx];
  endfunction

  function automatic void model_commit(input logic [3:0] cmd, input logic [31:0] addr,
                                       input logic [31:0] wd, input logic [3:0] be);
    int idx;
    idx = int'(addr[5:2]);
    if (cmd == 4'h2 && addr[7:6] == 2'b00 && idx >= 1 && idx <= 14) begin
      for (int b = 0; b < 4; b++)
        if (!be[b]) mregs[idx][8*b +: 8] = wd[8*b +: 8];
    end
    mcount = mcount + 32'd1;
  endfunction

  // Output compare on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("trdy", {31'b0, pci_trdy}, {31'b0, exp_trdy});
      chk("devsel", {31'b0, pci_devsel}, {31'b0, exp_devsel});
      chk("data", pci_data, exp_data);
      if (pci_devsel === 1'b0) dev_tot++;
      if (pci_trdy === 1'b0) trdy_tot++;
    end
  end

  task automatic do_reset();
    pci_rst_n = 1'b0;
    pci_frame = 1'b1;
    pci_irdy  = 1'b1;
    model_clear();
    exp_trdy = 1'b1; exp_devsel = 1'b1; exp_data = '0;
    repeat (2) @(posedge clk);
    #1 pci_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One address phase plus one data phase; hold = irdy-high edges spent in DATA.
  task automatic txn(input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int hold, output logic [31:0] rd);
    logic claimed;
    claimed = (cmd == 4'h1) || (cmd == 4'h2);
    rd = '0;
    pci_frame = 1'b0; pci_addr = addr; pci_cbe = cmd; pci_irdy = 1'b1;
    @(posedge clk); #1;
    pci_frame = 1'b1; pci_cbe = be; pci_wdata = wd;
    pci_irdy = (hold == 0) ? 1'b0 : 1'b1;
    if (!claimed) begin
      @(posedge clk); #1;
    end else begin
      exp_devsel = 1'b0;
      repeat (W) begin @(posedge clk); #1; end
      exp_trdy = 1'b0;
      exp_data = model_read(cmd, addr);
      rd = pci_data;
      repeat (hold) begin @(posedge clk); #1; end
      pci_irdy = 1'b0;
      @(posedge clk); #1;
      model_commit(cmd, addr, wd, be);
      exp_trdy = 1'b1; exp_devsel = 1'b1; exp_data = '0;
      pci_irdy = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    logic [31:0] rd;
    int d0, t0;
    pci_rst_n = 1'b0; pci_frame = 1'b1; pci_irdy = 1'b1;
    pci_addr = '0; pci_cbe = '0; pci_wdata = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 pci_rst_n = 1'b1;

    // Idle bus: nothing claimed for 10 cycles.
    d0 = dev_tot; t0 = trdy_tot;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_devsel_cycles", 32'(dev_tot - d0), 32'd0);
    chk("idle_trdy_cycles", 32'(trdy_tot - t0), 32'd0);

    // Minimum read of the ID dword.
    d0 = dev_tot; t0 = trdy_tot;
    txn(4'h1, 32'h00, '0, 4'h0, 0, rd);
    chk("id_read", rd, 32'h5678_1234);
    chk("min_devsel_cycles", 32'(dev_tot - d0), 32'd2);
    chk("min_trdy_cycles", 32'(trdy_tot - t0), 32'd1);

    // Byte-enabled write, counter, read-only and out-of-range handling.
    do_reset();
    txn(4'h2, 32'h04, 32'hDEAD_BEEF, 4'b1010, 0, rd);
    txn(4'h1, 32'h3C, '0, 4'h0, 0, rd);
    chk("count_after_write", rd, 32'h0000_0001);
    txn(4'h1, 32'h04, '0, 4'h0, 0, rd);
    chk("byte_lane_write", rd, 32'h00AD_00EF);
    txn(4'h2, 32'h00, 32'hFFFF_FFFF, 4'h0, 0, rd);
    txn(4'h1, 32'h00, '0, 4'h0, 0, rd);
    chk("ro_id_kept", rd, 32'h5678_1234);
    txn(4'h2, 32'h44, 32'h1234_5678, 4'h0, 0, rd);
    txn(4'h1, 32'h44, '0, 4'h0, 0, rd);
    chk("oor_read_zero", rd, 32'h0);
    txn(4'h1, 32'h04, '0, 4'h0, 0, rd);
    chk("oor_write_discarded", rd, 32'h00AD_00EF);
    txn(4'h2, 32'h38, 32'hA5A5_5A5A, 4'h0, 0, rd);
    txn(4'h1, 32'h38, '0, 4'h0, 0, rd);
    chk("full_word_dw14", rd, 32'hA5A5_5A5A);
    txn(4'h1, 32'h3C, '0, 4'h0, 0, rd);
    chk("count_after_ten", rd, 32'h0000_000A);

    // Unclaimed command.
    do_reset();
    d0 = dev_tot; t0 = trdy_tot;
    txn(4'h3, 32'h08, '0, 4'h0, 0, rd);
    chk("unclaimed_devsel_cycles", 32'(dev_tot - d0), 32'd0);
    chk("unclaimed_trdy_cycles", 32'(trdy_tot - t0), 32'd0);
    txn(4'h1, 32'h3C, '0, 4'h0, 0, rd);
    chk("unclaimed_no_count", rd, 32'h0);

    // Master holds irdy high for 5 edges in DATA.
    t0 = trdy_tot;
    txn(4'h1, 32'h00, '0, 4'h0, 5, rd);
    chk("hold_read", rd, 32'h5678_1234);
    chk("hold_trdy_cycles", 32'(trdy_tot - t0), 32'd6);

    // Reset during WAIT of a write to 0x08.
    pci_frame = 1'b0; pci_addr = 32'h08; pci_cbe = 4'h2; pci_irdy = 1'b1;
    @(posedge clk); #1;
    exp_devsel = 1'b0;
    pci_frame = 1'b1; pci_cbe = 4'h0; pci_wdata = 32'hFFFF_FFFF; pci_irdy = 1'b0;
    @(negedge clk);
    #1 pci_rst_n = 1'b0;
    exp_devsel = 1'b1; exp_trdy = 1'b1; exp_data = '0;
    model_clear();
    #1;
    chk("async_rst_devsel", {31'b0, pci_devsel}, 32'd1);
    chk("async_rst_trdy", {31'b0, pci_trdy}, 32'd1);
    pci_irdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 pci_rst_n = 1'b1;
    @(posedge clk); #1;
    txn(4'h1, 32'h08, '0, 4'h0, 0, rd);
    chk("partial_write_dropped", rd, 32'h0);
    txn(4'h1, 32'h3C, '0, 4'h0, 0, rd);
    chk("count_after_reset", rd, 32'h0000_0001);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
